// File: rtl/goal_score_ctl_pkg.sv
// Shared definitions for the referee stage: state encodings, field geometry and game defaults.
// draw_ball_ctl imports the same package so both sides agree on the goal mouth.
package goal_score_ctl_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [11:0] LEFT_GOAL_X_DEF  = 12'd40;
    localparam logic [11:0] RIGHT_GOAL_X_DEF = 12'd984;
    localparam logic [11:0] GOAL_Y_MIN_DEF   = 12'd284;
    localparam logic [11:0] GOAL_Y_MAX_DEF   = 12'd484;
    localparam logic [3:0]  WIN_SCORE_DEF    = 4'd7;
    localparam logic [7:0]  HOLD_FRAMES_DEF  = 8'd60;

    function automatic logic in_window(input logic [11:0] v,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/goal_score_ctl_rise_edge_det.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of d.
// Used for the frame tick and reusable for debounced button inputs.
module rise_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/goal_score_ctl.sv
// Referee stage: detects goals once per frame, keeps scores and sequences
// goal-hold, serve and game-over for the ball controller.
module goal_score_ctl
    import goal_score_ctl_pkg::*;
#(
    parameter logic [11:0] LEFT_GOAL_X  = LEFT_GOAL_X_DEF,
    parameter logic [11:0] RIGHT_GOAL_X = RIGHT_GOAL_X_DEF,
    parameter logic [11:0] GOAL_Y_MIN   = GOAL_Y_MIN_DEF,
    parameter logic [11:0] GOAL_Y_MAX   = GOAL_Y_MAX_DEF,
    parameter logic [3:0]  WIN_SCORE    = WIN_SCORE_DEF,
    parameter logic [7:0]  HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] xpos_ball,
    input  logic [11:0] ypos_ball,
    input  logic        restart,
    output logic [3:0]  player_1_score,
    output logic [3:0]  player_2_score,
    output logic        freeze,
    output logic        ball_reset,
    output logic        serve_to,
    output logic        game_over
);

    state_e      state_q, state_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [7:0]  hold_q, hold_d;
    logic        freeze_q, freeze_d;
    logic        ball_reset_q, ball_reset_d;
    logic        serve_to_q, serve_to_d;
    logic        game_over_q, game_over_d;
    logic        tick;
    logic        in_mouth, left_goal, right_goal;
    logic [3:0]  new_score;

    rise_edge_det u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (vblnk_in),
        .pulse  (tick)
    );

    assign in_mouth   = in_window(ypos_ball, GOAL_Y_MIN, GOAL_Y_MAX);
    assign left_goal  = tick && in_mouth && (xpos_ball <= LEFT_GOAL_X);
    assign right_goal = tick && in_mouth && (xpos_ball >= RIGHT_GOAL_X);

    always_comb begin
        state_d      = state_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        hold_d       = hold_q;
        freeze_d     = freeze_q;
        ball_reset_d = 1'b0;
        serve_to_d   = serve_to_q;
        game_over_d  = game_over_q;
        new_score    = 4'd0;

        // restart wins over any frame tick, whatever the current state
        if (restart) begin
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            game_over_d = 1'b0;
            hold_d      = 8'd0;
            state_d     = ST_SERVE;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (left_goal) begin
                        new_score  = p2_q + 4'd1;
                        p2_d       = new_score;
                        serve_to_d = 1'b0;
                    end else if (right_goal) begin
                        new_score  = p1_q + 4'd1;
                        p1_d       = new_score;
                        serve_to_d = 1'b1;
                    end
                    if (left_goal || right_goal) begin
                        freeze_d = 1'b1;
                        if (new_score == WIN_SCORE) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_FRAMES - 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (hold_q == 8'd0) begin
                            state_d = ST_SERVE;
                        end else begin
                            hold_d = hold_q - 8'd1;
                        end
                    end
                end
                ST_SERVE: begin
                    ball_reset_d = 1'b1;
                    freeze_d     = 1'b0;
                    state_d      = ST_PLAY;
                end
                ST_OVER: begin
                    freeze_d    = 1'b1;
                    game_over_d = 1'b1;
                end
                default: state_d = ST_PLAY;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PLAY;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            hold_q       <= 8'd0;
            freeze_q     <= 1'b0;
            ball_reset_q <= 1'b0;
            serve_to_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            hold_q       <= hold_d;
            freeze_q     <= freeze_d;
            ball_reset_q <= ball_reset_d;
            serve_to_q   <= serve_to_d;
            game_over_q  <= game_over_d;
        end
    end

    assign player_1_score = p1_q;
    assign player_2_score = p2_q;
    assign freeze         = freeze_q;
    assign ball_reset     = ball_reset_q;
    assign serve_to       = serve_to_q;
    assign game_over      = game_over_q;

endmodule
